bsg_axil_csr_slave: RTL



---
 rtl/bsg_axil_csr_pkg.sv | 15 +
 rtl/bsg_axil_csr_wr_join.sv | 77 +++++++
 rtl/bsg_axil_csr_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bsg_axil_csr_pkg.sv
// Shared AXI-Lite response encodings for the CSR slave and its write-channel join.
package bsg_axil_csr_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axil_resp_e;

   function automatic axil_resp_e resp_for(input logic in_range);
      return in_range ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/bsg_axil_csr_wr_join.sv
// Joins independently arriving AW and W beats into a single write commit and owns the B channel.
module bsg_axil_csr_wr_join
   import bsg_axil_csr_pkg::*;
#(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [addr_width_p-1:0]   aw_addr,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [data_width_p-1:0]   w_data,
   input  logic [data_width_p/8-1:0] w_strb,
   input  logic                      w_valid,
   output logic                      w_ready,
   output logic                      b_valid,
   output axil_resp_e                b_resp,
   input  logic                      b_ready,
   input  logic                      commit_ok,
   output logic                      commit_v,
   output logic [addr_width_p-1:0]   wr_addr,
   output logic [data_width_p-1:0]   wr_data,
   output logic [data_width_p/8-1:0] wr_strb
);

   logic                      aw_v_r;
   logic                      w_v_r;
   logic                      b_v_r;
   axil_resp_e                b_resp_r;
   logic [addr_width_p-1:0]   addr_r;
   logic [data_width_p-1:0]   data_r;
   logic [data_width_p/8-1:0] strb_r;

   assign aw_ready = ~aw_v_r & ~b_v_r;
   assign w_ready  = ~w_v_r & ~b_v_r;
   assign commit_v = aw_v_r & w_v_r & ~b_v_r;
   assign b_valid  = b_v_r;
   assign b_resp   = b_resp_r;
   assign wr_addr  = addr_r;
   assign wr_data  = data_r;
   assign wr_strb  = strb_r;

   // A holding register can never be loaded in its own commit cycle, since ready is low while it is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_v_r   <= 1'b0;
         w_v_r    <= 1'b0;
         b_v_r    <= 1'b0;
         b_resp_r <= RESP_OKAY;
         addr_r   <= '0;
         data_r   <= '0;
         strb_r   <= '0;
      end else begin
         if (aw_valid && aw_ready) begin
            aw_v_r <= 1'b1;
            addr_r <= aw_addr;
         end else if (commit_v) begin
            aw_v_r <= 1'b0;
         end
         if (w_valid && w_ready) begin
            w_v_r  <= 1'b1;
            data_r <= w_data;
            strb_r <= w_strb;
         end else if (commit_v) begin
            w_v_r <= 1'b0;
         end
         if (commit_v) begin
            b_v_r    <= 1'b1;
            b_resp_r <= resp_for(commit_ok);
         end else if (b_v_r && b_ready) begin
            b_v_r <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bsg_axil_csr_slave.sv
// AXI4-Lite slave exposing a bank of read/write CSRs; define BSG_AXIL_CSR_SLAVE_STATUS_EN
// to add a read-only status window directly above the CSRs.
module bsg_axil_csr_slave
   import bsg_axil_csr_pkg::*;
#(
   parameter int                    addr_width_p = 32,
   parameter int                    data_width_p = 32,
   parameter int                    num_regs_p   = 8,
   parameter logic [data_width_p-1:0] reset_val_p = '0
) (
   input  logic                               aclk_i,
   input  logic                               aresetn_i,
   input  logic [addr_width_p-1:0]            awaddr_i,
   input  logic [2:0]                         awprot_i,
   input  logic                               awvalid_i,
   output logic                               awready_o,
   input  logic [data_width_p-1:0]            wdata_i,
   input  logic [data_width_p/8-1:0]          wstrb_i,
   input  logic                               wvalid_i,
   output logic                               wready_o,
   output logic [1:0]                         bresp_o,
   output logic                               bvalid_o,
   input  logic                               bready_i,
   input  logic [addr_width_p-1:0]            araddr_i,
   input  logic [2:0]                         arprot_i,
   input  logic                               arvalid_i,
   output logic                               arready_o,
   output logic [data_width_p-1:0]            rdata_o,
   output logic [1:0]                         rresp_o,
   output logic                               rvalid_o,
   input  logic                               rready_i,
`ifdef BSG_AXIL_CSR_SLAVE_STATUS_EN
   input  logic [num_regs_p*data_width_p-1:0] status_i,
`endif
   output logic [num_regs_p*data_width_p-1:0] csr_data_o,
   output logic                               csr_wr_v_o,
   output logic [$clog2(num_regs_p)-1:0]      csr_wr_idx_o
);

   localparam int OFF_W = $clog2(data_width_p/8);
   localparam int IDX_W = $clog2(num_regs_p);
   localparam logic [addr_width_p-1:0] NUM_REGS_A = addr_width_p'(num_regs_p);
`ifdef BSG_AXIL_CSR_SLAVE_STATUS_EN
   localparam logic [addr_width_p-1:0] NUM_WORDS_A = addr_width_p'(2*num_regs_p);
`endif

   logic                      commit_v;
   logic                      commit_ok;
   logic                      csr_we;
   logic [addr_width_p-1:0]   wr_addr;
   logic [data_width_p-1:0]   wr_data;
   logic [data_width_p/8-1:0] wr_strb;
   logic [addr_width_p-1:0]   w_index;
   logic [addr_width_p-1:0]   r_index;
   axil_resp_e                b_resp;
   axil_resp_e                rd_resp;
   logic [data_width_p-1:0]   rd_word;
   logic                      unused_prot;

   assign unused_prot = ^{awprot_i, arprot_i};

   bsg_axil_csr_wr_join #(
      .addr_width_p(addr_width_p),
      .data_width_p(data_width_p)
   ) wr_join (
      .clk      (aclk_i),
      .rst_n    (aresetn_i),
      .aw_addr  (awaddr_i),
      .aw_valid (awvalid_i),
      .aw_ready (awready_o),
      .w_data   (wdata_i),
      .w_strb   (wstrb_i),
      .w_valid  (wvalid_i),
      .w_ready  (wready_o),
      .b_valid  (bvalid_o),
      .b_resp   (b_resp),
      .b_ready  (bready_i),
      .commit_ok(commit_ok),
      .commit_v (commit_v),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb)
   );

   assign bresp_o = b_resp;

   // The status window is read-only, so only true CSR indices are writable.
   assign w_index      = wr_addr >> OFF_W;
   assign commit_ok    = (w_index < NUM_REGS_A);
   assign csr_we       = commit_v & commit_ok;
   assign csr_wr_v_o   = csr_we;
   assign csr_wr_idx_o = w_index[IDX_W-1:0];

   for (genvar gi = 0; gi < num_regs_p; gi++) begin : g_csr
      logic [data_width_p-1:0] word_r;

      always_ff @(posedge aclk_i or negedge aresetn_i) begin
         if (!aresetn_i) begin
            word_r <= reset_val_p;
         end else if (csr_we && (w_index[IDX_W-1:0] == IDX_W'(gi))) begin
            for (int b = 0; b < data_width_p/8; b++) begin
               if (wr_strb[b]) word_r[b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end

      assign csr_data_o[gi*data_width_p +: data_width_p] = word_r;
   end

   assign r_index = araddr_i >> OFF_W;

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_SLVERR;
      if (r_index < NUM_REGS_A) begin
         rd_word = csr_data_o[int'(r_index[IDX_W-1:0])*data_width_p +: data_width_p];
         rd_resp = RESP_OKAY;
      end
`ifdef BSG_AXIL_CSR_SLAVE_STATUS_EN
      else if (r_index < NUM_WORDS_A) begin
         rd_word = status_i[int'(r_index[IDX_W-1:0])*data_width_p +: data_width_p];
         rd_resp = RESP_OKAY;
      end
`endif
   end

   assign arready_o = ~rvalid_o;

   // Read data is captured from the pre-edge CSR value, so a same-cycle commit is not visible.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         rresp_o  <= RESP_OKAY;
      end else if (arvalid_i && arready_o) begin
         rvalid_o <= 1'b1;
         rdata_o  <= rd_word;
         rresp_o  <= rd_resp;
      end else if (rvalid_o && rready_i) begin
         rvalid_o <= 1'b0;
      end
   end

endmodule
